// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit
package muldiv_pkg;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t                op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;

    // Multiply: {hi, lo} with the multiplier in lo. Divide: {rem, quot}
    // with the dividend shifted out of quot; the quotient bit is left to the caller.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, operand};
        q_bit    = 1'b0;
        rem_next = shifted[WIDTH-1:0];
        if (op == OP_DIV || op == OP_DIVU) begin
            q_bit = ~diff[WIDTH];
            if (q_bit) begin
                rem_next = diff[WIDTH-1:0];
            end
            acc_next = {rem_next, acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative HI/LO multiply/divide engine with busy stall
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             DivByZero
);
    localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t             state, state_next;
    op_t                op_q;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opnd_q, a_raw_q;
    logic               a_neg_q, b_neg_q, b_zero_q;
    logic               step_q_bit;

    op_t                op_in;
    logic               in_signed, in_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               q_div, dz_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_q),
        .acc      (acc),
        .operand  (opnd_q),
        .acc_next (acc_step),
        .q_bit    (step_q_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start && !Abort) state_next = S_RUN;
            S_RUN:   if (Abort) state_next = S_IDLE;
                     else if (count == LAST) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_in     = op_t'(Op);
        in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
        in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
        a_mag     = (in_signed && A[WIDTH-1]) ? -A : A;
        b_mag     = (in_signed && B[WIDTH-1]) ? -B : B;
    end

    // Sign flags are only ever set for signed ops, so unsigned ops pass through untouched.
    always_comb begin
        q_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        prod_fix = (a_neg_q ^ b_neg_q) ? -acc : acc;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        dz_fix   = 1'b0;
        if (q_div) begin
            if (b_zero_q) begin
                hi_fix = a_raw_q;
                lo_fix = '1;
                dz_fix = 1'b1;
            end else begin
                lo_fix = (a_neg_q ^ b_neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                hi_fix = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            count     <= '0;
            op_q      <= OP_MULT;
            acc       <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            HiOut     <= '0;
            LoOut     <= '0;
        end else begin
            state     <= state_next;
            Busy      <= (state_next != S_IDLE);
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_next == S_RUN) begin
                        op_q     <= op_in;
                        count    <= '0;
                        a_raw_q  <= A;
                        a_neg_q  <= in_signed && A[WIDTH-1];
                        b_neg_q  <= in_signed && B[WIDTH-1];
                        b_zero_q <= (B == '0);
                        opnd_q   <= in_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                    end
                end
                S_RUN: begin
                    count <= count + 1'b1;
                    acc   <= q_div ? {acc_step[2*WIDTH-1:1], step_q_bit} : acc_step;
                end
                S_FIX: begin
                    if (!Abort) begin
                        HiOut     <= hi_fix;
                        LoOut     <= lo_fix;
                        Done      <= 1'b1;
                        DivByZero <= dz_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst, Start, Abort;
    logic [1:0]   Op;
    logic [W-1:0] A, B;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] HiOut, LoOut;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    hilo_muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Abort     (Abort),
        .Busy      (Busy),
        .Done      (Done),
        .HiOut     (HiOut),
        .LoOut     (LoOut),
        .DivByZero (DivByZero)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Reference result {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Drives one request and waits (bounded) for Done; reports what was seen.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz,
                          output int lat, output int busy_cnt, output logic busy_at_done, output bit ok);
        Op = op; A = a; B = b; Start = 1'b1;
        hi = '0; lo = '0; dz = 1'b0; lat = 0; busy_cnt = 0; busy_at_done = 1'b0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (i == 0) Start = 1'b0;
            lat++;
            if (Done) begin
                hi = HiOut; lo = LoOut; dz = DivByZero; busy_at_done = Busy; ok = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] hi, lo;
        logic dz, bd;
        int lat, bc;
        bit ok;
        logic [2*W:0] exp;
        exp = model(op, a, b);
        run_op(op, a, b, hi, lo, dz, lat, bc, bd, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: no Done within 100 cycles", name);
        end else if ({dz, hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s op=%0d a=%h b=%h: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                     name, op, a, b, dz, hi, lo, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Op = 2'b00; A = '0; B = '0;
        tick; tick;
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", DivByZero); end
        checks++; if (HiOut !== '0)       begin errors++; $display("FAIL reset_hi: got %h expected 0", HiOut); end
        checks++; if (LoOut !== '0)       begin errors++; $display("FAIL reset_lo: got %h expected 0", LoOut); end
        Rst = 1'b0;
        tick;
    endtask

    task automatic test_mult;
        logic [W-1:0] hi, lo;
        logic dz, bd;
        int lat, bc;
        bit ok;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, dz, lat, bc, bd, ok);
        checks++; if (!ok || hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo: got %h expected 00000001", lo); end
        checks++; if (lat != 34)            begin errors++; $display("FAIL latency: got %0d expected 34", lat); end
        checks++; if (bc != 33)             begin errors++; $display("FAIL busy_cycles: got %0d expected 33", bc); end
        checks++; if (bd !== 1'b0)          begin errors++; $display("FAIL busy_at_done: got %b expected 0", bd); end
        check_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check_op("mult_negneg", OP_MULT, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_div;
        check_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check_op("divu_7_2", OP_DIVU, 32'd7, 32'd2);
        check_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE);
        check_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_zero;
        logic [W-1:0] hi, lo;
        logic dz, bd;
        int lat, bc;
        bit ok;
        run_op(OP_DIVU, 32'd5, 32'd0, hi, lo, dz, lat, bc, bd, ok);
        checks++; if (!ok || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd5)  begin errors++; $display("FAIL divz_hi: got %h expected 5", hi); end
        checks++; if (dz !== 1'b1)   begin errors++; $display("FAIL divz_flag: got %b expected 1", dz); end
        tick;
        checks++; if (DivByZero !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL divz_pulse: got dz=%b done=%b expected 0 0", DivByZero, Done);
        end
        check_op("div_signed_zero", OP_DIV, 32'hFFFF_FFF0, 32'd0);
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [W-1:0] a, b;
        int sel;
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -b;
            check_op($sformatf("random_%0d", n), op, a, b);
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        bit seen;
        Op = OP_MULTU; A = 32'd3; B = 32'd4; Start = 1'b1;
        tick; Start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        A = 32'd9; B = 32'd9; Start = 1'b1;
        tick; Start = 1'b0;
        seen = 1'b0; lat = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick;
            if (Done) seen = 1'b1;
        end
        checks++; if (!seen || HiOut !== 32'd0 || LoOut !== 32'd12) begin
            errors++; $display("FAIL start_busy_result: got seen=%b hi=%h lo=%h expected 1 0 c", seen, HiOut, LoOut);
        end
        for (int i = 0; i < 40; i++) begin
            tick;
            if (Done || Busy) lat++;
        end
        checks++; if (lat != 0) begin errors++; $display("FAIL start_busy_queued: got %0d active cycles expected 0", lat); end
    endtask

    task automatic test_abort;
        int spurious;
        Op = OP_MULTU; A = 32'd5; B = 32'd6; Start = 1'b1;
        tick; Start = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        Abort = 1'b1;
        tick; Abort = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_run_busy: got %b expected 0", Busy); end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin tick; if (Done) spurious++; end
        checks++; if (spurious != 0 || HiOut !== 32'd0 || LoOut !== 32'd12) begin
            errors++; $display("FAIL abort_run_hold: got dones=%0d hi=%h lo=%h expected 0 0 c", spurious, HiOut, LoOut);
        end
        Op = OP_MULTU; A = 32'd7; B = 32'd8; Start = 1'b1;
        tick; Start = 1'b0;
        for (int i = 0; i < 32; i++) tick;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_fix_busy_before: got %b expected 1", Busy); end
        Abort = 1'b1;
        tick; Abort = 1'b0;
        checks++; if (Done !== 1'b0 || Busy !== 1'b0 || LoOut !== 32'd12) begin
            errors++; $display("FAIL abort_fix: got done=%b busy=%b lo=%h expected 0 0 c", Done, Busy, LoOut);
        end
        Op = OP_MULTU; A = 32'd2; B = 32'd2; Start = 1'b1; Abort = 1'b1;
        tick; Start = 1'b0; Abort = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_idle_block: got busy=%b expected 0", Busy); end
        tick;
    endtask

    task automatic test_reset_mid;
        int spurious;
        Op = OP_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
        tick; Start = 1'b0;
        for (int i = 0; i < 20; i++) tick;
        Rst = 1'b1;
        tick; Rst = 1'b0;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || HiOut !== '0 || LoOut !== '0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", Busy, Done, HiOut, LoOut);
        end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin tick; if (Done || Busy) spurious++; end
        checks++; if (spurious != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", spurious); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] hi, lo;
        logic dz, bd;
        int lat, bc;
        bit ok;
        logic [2*W:0] exp;
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd10, hi, lo, dz, lat, bc, bd, ok);
        exp = model(OP_MULT, 32'hFFFF_FFFF, 32'd10);
        checks++; if (!ok || {hi, lo} !== exp[2*W-1:0]) begin
            errors++; $display("FAIL b2b_first: got %h_%h expected %h", hi, lo, exp[2*W-1:0]);
        end
        run_op(OP_DIVU, 32'd1000, 32'd33, hi, lo, dz, lat, bc, bd, ok);
        exp = model(OP_DIVU, 32'd1000, 32'd33);
        checks++; if (!ok || {dz, hi, lo} !== exp) begin
            errors++; $display("FAIL b2b_second: got %b_%h_%h expected %h", dz, hi, lo, exp);
        end
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_random;
        test_start_while_busy;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
